// File: rtl/noc_pkg.sv
// Shared types and defaults for the NoC router output-port arbiter.
package noc_pkg;

    localparam int NPORTS = 4;
    localparam int PORT_W = 2;
    localparam int FLIT_W = 32;

    // Arbiter state: no packet open, or a packet open on the granted port.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef logic [PORT_W-1:0] port_idx_t;

endpackage : noc_pkg

// File: rtl/noc_port_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: first requester at or after ptr.
module rr_pick
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  port_idx_t         ptr,
    output logic              any,
    output port_idx_t         idx
);

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        any = |req;
        idx = ptr;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (req[ptr + port_idx_t'(k)]) begin
                idx = ptr + port_idx_t'(k);
            end
        end
    end

endmodule : rr_pick

// File: rtl/noc_port_arbiter.sv
// Packet-locked round-robin arbiter with output register for one crossbar output.
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int NPORTS = noc_pkg::NPORTS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        in_valid,
    output logic [NPORTS-1:0]        in_ready,
    input  logic [NPORTS*FLIT_W-1:0] in_flit,
    input  logic [NPORTS-1:0]        in_tail,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_tail,
    output logic [PORT_W-1:0]        out_sel,
    output logic                     locked
);

    arb_state_e  state_q, state_d;
    port_idx_t   ptr_q, ptr_d;
    port_idx_t   gnt_q, gnt_d;

    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic              out_tail_q;
    port_idx_t         out_sel_q;

    logic              ld;
    logic              pick_any;
    port_idx_t         pick_idx;
    logic              xfer;
    port_idx_t         src;
    logic              src_tail;
    logic [FLIT_W-1:0] src_flit;

    // The output register can take a new flit when empty or draining this cycle.
    assign ld = !out_valid_q || out_ready;

    rr_pick u_rr_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Transfer decode: arbitrate while idle, follow the granted port while locked.
    always_comb begin
        xfer = 1'b0;
        src  = gnt_q;
        if (state_q == IDLE) begin
            src  = pick_idx;
            xfer = ld && pick_any;
        end else begin
            xfer = ld && in_valid[gnt_q];
        end
    end

    assign src_tail = in_tail[src];
    assign src_flit = in_flit[src*FLIT_W +: FLIT_W];

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next state: a non-tail win opens a packet, a tail transfer closes it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        if (xfer) begin
            if (src_tail) begin
                state_d = IDLE;
                ptr_d   = src + port_idx_t'(1);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                gnt_d   = src;
            end
        end
    end

    // Outputs: one-hot accept for the transferring port and the lock flag.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[src] = 1'b1;
        end
        locked = (state_q == LOCKED);
    end

    // Output register: load on transfer, clear valid on drain, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_tail_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_flit_q  <= src_flit;
            out_tail_q  <= src_tail;
            out_sel_q   <= src;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_tail  = out_tail_q;
    assign out_sel   = out_sel_q;

endmodule : noc_port_arbiter

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter with hand-computed expectations.
module tb_noc_port_arbiter;

    localparam int FW = 32;

    logic            clk;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [4*FW-1:0] in_flit;
    logic [3:0]      in_tail;
    logic            out_valid;
    logic            out_ready;
    logic [FW-1:0]   out_flit;
    logic            out_tail;
    logic [1:0]      out_sel;
    logic            locked;

    int vectors;
    int miscompares;

    noc_port_arbiter #(.FLIT_W(FW), .NPORTS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .in_tail   (in_tail),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .out_tail  (out_tail),
        .out_sel   (out_sel),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_flit(input int p, input logic [FW-1:0] v);
        in_flit[p*FW +: FW] = v;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] t);
        in_valid = v;
        in_tail  = t;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; in_flit = '0; drive(4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_flit !== '0) begin miscompares++; $display("FAIL rst_out_flit: got %h want 0", out_flit); end
        vectors++; if (out_sel !== 2'd0) begin miscompares++; $display("FAIL rst_out_sel: got %0d want 0", out_sel); end
        vectors++; if (out_tail !== 1'b0 || locked !== 1'b0) begin miscompares++; $display("FAIL rst_tail_locked: got %b%b want 00", out_tail, locked); end
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_priority();
        logic [1:0] e;
        for (int p = 0; p < 4; p++) set_flit(p, 32'h100 + p);
        drive(4'b1111, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 4);
            #1;
            vectors++; if (in_ready !== (4'b0001 << e)) begin miscompares++; $display("FAIL prio_ready[%0d]: got %b want %b", i, in_ready, 4'b0001 << e); end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_sel !== e) begin miscompares++; $display("FAIL prio_out[%0d]: got v=%b sel=%0d want v=1 sel=%0d", i, out_valid, out_sel, e); end
            vectors++; if (out_flit !== 32'h100 + 32'(e) || out_tail !== 1'b1 || locked !== 1'b0) begin miscompares++; $display("FAIL prio_flit[%0d]: got %h t=%b l=%b want %h t=1 l=0", i, out_flit, out_tail, locked, 32'h100 + 32'(e)); end
        end
        drive(4'b0000, 4'b0000);
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL prio_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_packet_lock();
        logic [FW-1:0] pkt [3];
        pkt[0] = 32'hA0; pkt[1] = 32'hA1; pkt[2] = 32'hA2;
        // Move the pointer from 1 to 2 with a single-flit packet on port 1.
        set_flit(1, 32'h111); drive(4'b0010, 4'b0010);
        tick();
        for (int f = 0; f < 3; f++) begin
            set_flit(2, pkt[f]);
            drive(4'b1111, (f == 2) ? 4'b1111 : 4'b1011);
            #1;
            vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL lock_ready[%0d]: got %b want 0100", f, in_ready); end
            tick();
            vectors++; if (out_flit !== pkt[f] || out_sel !== 2'd2) begin miscompares++; $display("FAIL lock_out[%0d]: got %h sel=%0d want %h sel=2", f, out_flit, out_sel, pkt[f]); end
            vectors++; if (locked !== (f != 2) || out_tail !== (f == 2)) begin miscompares++; $display("FAIL lock_flags[%0d]: got l=%b t=%b", f, locked, out_tail); end
        end
        #1;
        vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL lock_next_ready: got %b want 1000", in_ready); end
        tick();
        vectors++; if (out_sel !== 2'd3 || out_flit !== 32'h103) begin miscompares++; $display("FAIL lock_next_out: got sel=%0d %h want sel=3 103", out_sel, out_flit); end
        drive(4'b0000, 4'b0000);
        tick();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] pkt [4];
        pkt[0] = 32'hB0; pkt[1] = 32'hB1; pkt[2] = 32'hB2; pkt[3] = 32'hB3;
        set_flit(1, 32'h101);
        for (int f = 0; f < 2; f++) begin
            set_flit(0, pkt[f]); drive(4'b0011, 4'b0010);
            tick();
            vectors++; if (out_flit !== pkt[f] || out_sel !== 2'd0 || locked !== 1'b1) begin miscompares++; $display("FAIL bp_pre[%0d]: got %h sel=%0d l=%b want %h sel=0 l=1", f, out_flit, out_sel, locked, pkt[f]); end
        end
        set_flit(0, pkt[2]);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_flit !== pkt[1]) begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", c, out_valid, out_flit, pkt[1]); end
        end
        out_ready = 1'b1;
        for (int f = 2; f < 4; f++) begin
            set_flit(0, pkt[f]); drive(4'b0011, (f == 3) ? 4'b0011 : 4'b0010);
            #1;
            vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_rel_ready[%0d]: got %b want 0001", f, in_ready); end
            tick();
            vectors++; if (out_flit !== pkt[f] || out_tail !== (f == 3)) begin miscompares++; $display("FAIL bp_rel_out[%0d]: got %h t=%b want %h", f, out_flit, out_tail, pkt[f]); end
        end
        drive(4'b0000, 4'b0000);
        tick();
    endtask

    task automatic test_bubble();
        set_flit(0, 32'h100);
        set_flit(1, 32'hC0); drive(4'b0011, 4'b0001);
        #1;
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL bub_head_ready: got %b want 0010", in_ready); end
        tick();
        vectors++; if (out_flit !== 32'hC0 || locked !== 1'b1) begin miscompares++; $display("FAIL bub_head_out: got %h l=%b want C0 l=1", out_flit, locked); end
        drive(4'b0001, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL bub_gap_ready[%0d]: got %b want 0000", c, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b0 || locked !== 1'b1) begin miscompares++; $display("FAIL bub_gap_out[%0d]: got v=%b l=%b want v=0 l=1", c, out_valid, locked); end
        end
        set_flit(1, 32'hC1); drive(4'b0011, 4'b0001);
        #1;
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL bub_body_ready: got %b want 0010", in_ready); end
        tick();
        set_flit(1, 32'hC2); drive(4'b0011, 4'b0011);
        tick();
        vectors++; if (out_flit !== 32'hC2 || out_sel !== 2'd1 || locked !== 1'b0) begin miscompares++; $display("FAIL bub_tail_out: got %h sel=%0d l=%b want C2 sel=1 l=0", out_flit, out_sel, locked); end
        drive(4'b0001, 4'b0001);
        #1;
        vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL bub_after_ready: got %b want 0001", in_ready); end
        tick();
        drive(4'b0000, 4'b0000);
        tick();
    endtask

    task automatic test_reset_mid_packet();
        set_flit(3, 32'hD0); drive(4'b1000, 4'b0000);
        tick();
        vectors++; if (locked !== 1'b1 || out_sel !== 2'd3) begin miscompares++; $display("FAIL rmp_locked: got l=%b sel=%0d want l=1 sel=3", locked, out_sel); end
        rst_n = 1'b0; drive(4'b0000, 4'b0000);
        #1;
        vectors++; if (out_valid !== 1'b0 || locked !== 1'b0) begin miscompares++; $display("FAIL rmp_clear: got v=%b l=%b want 0 0", out_valid, locked); end
        vectors++; if (dut.ptr_q !== 2'd0) begin miscompares++; $display("FAIL rmp_ptr: got %0d want 0", dut.ptr_q); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_flit(0, 32'hE0); set_flit(3, 32'hE3); drive(4'b1001, 4'b1001);
        #1;
        vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL rmp_first_ready: got %b want 0001", in_ready); end
        tick();
        vectors++; if (out_sel !== 2'd0 || out_flit !== 32'hE0) begin miscompares++; $display("FAIL rmp_first_out: got sel=%0d %h want sel=0 E0", out_sel, out_flit); end
        drive(4'b0000, 4'b0000);
        tick();
    endtask

    task automatic test_idle_ptr_hold();
        // Pointer is 1; a single-flit win on port 1 moves it to 2.
        set_flit(1, 32'hF1); drive(4'b0010, 4'b0010);
        tick();
        drive(4'b0000, 4'b0000);
        for (int c = 0; c < 10; c++) begin
            #1;
            vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL idle_ready[%0d]: got %b want 0000", c, in_ready); end
            tick();
        end
        set_flit(2, 32'hF2); drive(4'b0110, 4'b0110);
        #1;
        vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL idle_first_ready: got %b want 0100", in_ready); end
        tick();
        vectors++; if (out_sel !== 2'd2 || out_flit !== 32'hF2) begin miscompares++; $display("FAIL idle_first_out: got sel=%0d %h want sel=2 F2", out_sel, out_flit); end
        #1;
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL idle_second_ready: got %b want 0010", in_ready); end
        tick();
        vectors++; if (out_sel !== 2'd1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL idle_second_out: got sel=%0d v=%b want sel=1 v=1", out_sel, out_valid); end
        drive(4'b0000, 4'b0000);
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_reset_priority();
        test_packet_lock();
        test_backpressure();
        test_bubble();
        test_reset_mid_packet();
        test_idle_ptr_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_noc_port_arbiter

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Four-input, packet-locked round-robin arbiter and output register for one crossbar output of the FCUDA NoC router. It sits directly upstream of the crossbar's 4:1 mux LUT stage. It picks one of four input-port flit streams, holds that choice for a whole packet (head through tail), and presents the winning flit together with the 2-bit mux select that steers the downstream mux.

## Interface
Parameters:
- FLIT_W, 32, flit payload width in bits.
- NPORTS, 4, number of input ports; fixed at 4 (select is 2 bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  4  per-port flit valid.
- in_ready  out  4  per-port flit accept; at most one bit high per cycle.
- in_flit  in  4*FLIT_W  port p occupies bits [p*FLIT_W +: FLIT_W].
- in_tail  in  4  flit is the last of its packet; head+tail in one flit is legal.
- out_valid  out  1  output register holds a flit.
- out_ready  in  1  downstream accepts.
- out_flit  out  FLIT_W  registered flit.
- out_tail  out  1  registered tail flag.
- out_sel  out  2  source port of the registered flit; drives the mux LUT controls.
- locked  out  1  a packet is in progress (head sent, tail not yet sent).

## Operation
- State machine:
  - IDLE: no packet open.
  - LOCKED: packet open on port `gnt`.
- Load enable: `ld = !out_valid || out_ready`.
- IDLE behaviour:
  - Round-robin pick over `in_valid`, starting at pointer `ptr` and searching ptr, ptr+1, … mod 4.
  - If `ld` is high and some port is valid, that port gets `in_ready`.
  - The flit transfers in the same cycle.
  - Winning flit is non-tail: go to LOCKED with `gnt` = winner.
  - Winning flit is tail: stay IDLE and set `ptr` = winner+1 mod 4.
- LOCKED behaviour:
  - Only port `gnt` may get `in_ready`, and only when `in_valid[gnt] && ld`.
  - Other ports' valids are ignored.
  - Transferring a tail flit returns the FSM to IDLE and sets `ptr` = gnt+1 mod 4.
- Output register:
  - On any input transfer, load `out_flit`, `out_tail`, `out_sel` (= source port) and set `out_valid`.
  - If `out_ready` is high and there is no transfer, clear `out_valid`.
  - `out_flit`, `out_tail` and `out_sel` hold while `out_valid && !out_ready`.
- `ptr` is unchanged when no packet completes, including idle cycles.
- `in_ready` is a combinational function of state, `ptr`, `in_valid` and `out_ready`.
- `in_ready` never depends on `in_flit` or `in_tail` contents.

## Timing
- Reset values:
  - out_valid=0, out_flit=0, out_tail=0, out_sel=0, locked=0.
  - State IDLE, ptr=0, gnt=0.
  - in_ready=0 follows combinationally.
- Latency: 1 cycle. A flit accepted at edge N appears on out_* after edge N.
- Throughput: 1 flit/cycle when `out_ready` is held high.
- Backpressure: while `out_valid && !out_ready`, all `in_ready` are 0 and the output holds.
- Simultaneous events:
  - Output drain and a new load in the same cycle: the register reloads and `out_valid` stays 1.
  - A tail transfer and a new head in the same cycle cannot occur; the next packet is arbitrated the following cycle.
- Bubbles: a gap in `in_valid[gnt]` while LOCKED stalls the packet. No other port may interleave.
- Reset mid-packet: immediate return to reset values. The open packet is abandoned; upstream is responsible for flushing it.
- `locked` is 1 exactly while the state is LOCKED.

## Structure
- Package `noc_pkg` holds:
  - NPORTS, PORT_W (=2) and FLIT_W defaults.
  - State typedef {IDLE, LOCKED}.
  - Port-index typedef.
- Sub-module `rr_pick`: combinational 4-way round-robin picker.
  - Inputs: req[4], ptr[2].
  - Outputs: any, idx[2].
  - The arbiter instantiates it once.
- Remaining logic (FSM, `ptr`/`gnt` registers, output register, `in_ready` decode) lives in the top module.

## Test plan
- Reset priority: after reset, in_valid=4'b1111 with all flits single-flit tail, out_ready=1.
  - Grants in order 0,1,2,3,0.
  - `out_sel` sequence 0,1,2,3,0, one per cycle.
- Packet lock: port 2 sends a 3-flit packet (0xA0, 0xA1, 0xA2 with tail) while ports 0/1/3 are valid.
  - Outputs are 0xA0, 0xA1, 0xA2 consecutively with out_sel=2 and locked=1, then ptr=3.
  - Port 3 is granted next.
- Backpressure: out_ready=0 for 5 cycles mid-packet.
  - `out_flit` is stable and in_ready=0 throughout.
  - After release, no flit is lost or duplicated.
- Bubble inside packet: in_valid[1] drops for 3 cycles mid-packet while port 0 is valid.
  - Port 0 is never granted until port 1's tail transfers.
- Reset mid-packet: assert rst_n=0 while LOCKED on port 3.
  - out_valid=0, locked=0 and ptr=0 immediately.
  - The next request from port 0 is granted first.
- Idle pointer hold: ptr=2, then 10 cycles with no requests, then ports 1 and 2 request.
  - Port 2 is granted first.
